// File: rtl/decode_pkg.sv
// Shared types and encodings for the decode issue queue: control bundle, issue classes,
// MIPS opcode/funct/rt field values and ALU operation codes.
package decode_pkg;

  typedef struct packed {
    logic       wreg;
    logic       regdst;
    logic       use_imm;
    logic       branch;
    logic       wmem;
    logic       rmem;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       bal;
    logic       jalr;
    logic [5:0] alucontrol;
    logic       memen;
    logic [1:0] whilo;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {IC_NORMAL, IC_MEM, IC_BRANCH, IC_SINGLE} issue_class_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F, OP_COP0   = 6'h10, OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21, OP_LW     = 6'h23, OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B, OP_CACHE  = 6'h2F, OP_LL    = 6'h30;
  localparam logic [5:0] OP_SC      = 6'h38;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09;
  localparam logic [5:0] FN_SYSC = 6'h0C, FN_BREAK = 6'h0D, FN_SYNC = 6'h0F, FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11, FN_MFLO  = 6'h12, FN_MTLO = 6'h13, FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B, FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB   = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_XOR   = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B, FN_TGE   = 6'h30, FN_TGEU = 6'h31, FN_TLT   = 6'h32;
  localparam logic [5:0] FN_TLTU = 6'h33, FN_TEQ   = 6'h34, FN_TNE  = 6'h36;

  // COP0 CO-space funct values
  localparam logic [5:0] FN_TLBR = 6'h01, FN_TLBWI = 6'h02, FN_TLBWR = 6'h06, FN_TLBP = 6'h08;
  localparam logic [5:0] FN_ERET = 6'h18;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_TGEI = 5'h08, RT_TGEIU = 5'h09;
  localparam logic [4:0] RT_TLTI = 5'h0A, RT_TLTIU = 5'h0B, RT_TEQI = 5'h0C, RT_TNEI = 5'h0E;
  localparam logic [4:0] RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;

  localparam logic [5:0] ALU_ADD  = 6'd0,  ALU_ADDU = 6'd1,  ALU_SUB  = 6'd2,  ALU_SUBU = 6'd3;
  localparam logic [5:0] ALU_AND  = 6'd4,  ALU_OR   = 6'd5,  ALU_XOR  = 6'd6,  ALU_NOR  = 6'd7;
  localparam logic [5:0] ALU_SLT  = 6'd8,  ALU_SLTU = 6'd9,  ALU_SLL  = 6'd10, ALU_SRL  = 6'd11;
  localparam logic [5:0] ALU_SRA  = 6'd12, ALU_LUI  = 6'd13, ALU_MULT = 6'd14, ALU_MULTU = 6'd15;
  localparam logic [5:0] ALU_DIV  = 6'd16, ALU_DIVU = 6'd17, ALU_MFHI = 6'd18, ALU_MFLO = 6'd19;
  localparam logic [5:0] ALU_MTHI = 6'd20, ALU_MTLO = 6'd21, ALU_MFC0 = 6'd22, ALU_MTC0 = 6'd23;
  localparam logic [5:0] ALU_ERET = 6'd24, ALU_SYSC = 6'd25, ALU_BRK  = 6'd26, ALU_TRAP = 6'd27;

endpackage

// File: rtl/decode_slot.sv
// Combinational single-instruction decoder: control bundle, issue class, destination and
// source-register usage for the pairing checks.
module decode_slot
  import decode_pkg::*;
(
  input  logic [31:0]  instr_i,
  output ctrl_t        ctrl_o,
  output issue_class_e class_o,
  output logic         invalid_o,
  output logic [4:0]   dst_o,
  output logic [4:0]   rs_o,
  output logic [4:0]   rt_o,
  output logic         rs_used_o,
  output logic         rt_used_o
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       unused_sa;

  assign op        = instr_i[31:26];
  assign rs        = instr_i[25:21];
  assign rt        = instr_i[20:16];
  assign rd        = instr_i[15:11];
  assign funct     = instr_i[5:0];
  assign rs_o      = rs;
  assign rt_o      = rt;
  assign unused_sa = ^instr_i[10:6];

  always_comb begin
    ctrl_o    = '0;
    class_o   = IC_NORMAL;
    invalid_o = 1'b0;
    dst_o     = '0;
    rs_used_o = 1'b0;
    rt_used_o = 1'b0;
    case (op)
      OP_SPECIAL: begin
        ctrl_o.wreg   = 1'b1;
        ctrl_o.regdst = 1'b1;
        dst_o         = rd;
        rs_used_o     = 1'b1;
        rt_used_o     = 1'b1;
        case (funct)
          FN_SLL:  begin rs_used_o = 1'b0; ctrl_o.alucontrol = ALU_SLL; end
          FN_SRL:  begin rs_used_o = 1'b0; ctrl_o.alucontrol = ALU_SRL; end
          FN_SRA:  begin rs_used_o = 1'b0; ctrl_o.alucontrol = ALU_SRA; end
          FN_SLLV: ctrl_o.alucontrol = ALU_SLL;
          FN_SRLV: ctrl_o.alucontrol = ALU_SRL;
          FN_SRAV: ctrl_o.alucontrol = ALU_SRA;
          FN_JR: begin
            ctrl_o    = '0;
            ctrl_o.jr = 1'b1;
            dst_o     = '0;
            rt_used_o = 1'b0;
            class_o   = IC_BRANCH;
          end
          FN_JALR: begin
            ctrl_o.jalr = 1'b1;
            rt_used_o   = 1'b0;
            class_o     = IC_BRANCH;
          end
          FN_SYSC, FN_BREAK: begin
            ctrl_o            = '0;
            ctrl_o.alucontrol = (funct == FN_SYSC) ? ALU_SYSC : ALU_BRK;
            {dst_o, rs_used_o, rt_used_o} = '0;
            class_o           = IC_SINGLE;
          end
          FN_SYNC: begin
            ctrl_o = '0;
            {dst_o, rs_used_o, rt_used_o} = '0;
          end
          FN_MFHI, FN_MFLO: begin
            ctrl_o.alucontrol = (funct == FN_MFHI) ? ALU_MFHI : ALU_MFLO;
            {rs_used_o, rt_used_o} = '0;
            class_o           = IC_SINGLE;
          end
          FN_MTHI, FN_MTLO: begin
            ctrl_o            = '0;
            ctrl_o.whilo      = (funct == FN_MTHI) ? 2'b10 : 2'b01;
            ctrl_o.alucontrol = (funct == FN_MTHI) ? ALU_MTHI : ALU_MTLO;
            dst_o             = '0;
            rt_used_o         = 1'b0;
            class_o           = IC_SINGLE;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            ctrl_o            = '0;
            ctrl_o.whilo      = 2'b11;
            ctrl_o.alucontrol = ALU_MULT + {4'd0, funct[1:0]};
            dst_o             = '0;
            class_o           = IC_SINGLE;
          end
          FN_ADD:  ctrl_o.alucontrol = ALU_ADD;
          FN_ADDU: ctrl_o.alucontrol = ALU_ADDU;
          FN_SUB:  ctrl_o.alucontrol = ALU_SUB;
          FN_SUBU: ctrl_o.alucontrol = ALU_SUBU;
          FN_AND:  ctrl_o.alucontrol = ALU_AND;
          FN_OR:   ctrl_o.alucontrol = ALU_OR;
          FN_XOR:  ctrl_o.alucontrol = ALU_XOR;
          FN_NOR:  ctrl_o.alucontrol = ALU_NOR;
          FN_SLT:  ctrl_o.alucontrol = ALU_SLT;
          FN_SLTU: ctrl_o.alucontrol = ALU_SLTU;
          FN_TGE, FN_TGEU, FN_TLT, FN_TLTU, FN_TEQ, FN_TNE: begin
            ctrl_o            = '0;
            ctrl_o.alucontrol = ALU_TRAP;
            dst_o             = '0;
            class_o           = IC_SINGLE;
          end
          default: invalid_o = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        rs_used_o = 1'b1;
        case (rt)
          RT_BLTZ, RT_BGEZ: begin ctrl_o.branch = 1'b1; class_o = IC_BRANCH; end
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl_o.branch = 1'b1;
            ctrl_o.bal    = 1'b1;
            ctrl_o.wreg   = 1'b1;
            dst_o         = 5'd31;
            class_o       = IC_BRANCH;
          end
          RT_TGEI, RT_TGEIU, RT_TLTI, RT_TLTIU, RT_TEQI, RT_TNEI: begin
            ctrl_o.alucontrol = ALU_TRAP;
            ctrl_o.use_imm    = 1'b1;
            class_o           = IC_SINGLE;
          end
          default: invalid_o = 1'b1;
        endcase
      end
      OP_J:   begin ctrl_o.jump = 1'b1; class_o = IC_BRANCH; end
      OP_JAL: begin
        ctrl_o.jal  = 1'b1;
        ctrl_o.wreg = 1'b1;
        dst_o       = 5'd31;
        class_o     = IC_BRANCH;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl_o.branch = 1'b1;
        rs_used_o     = 1'b1;
        rt_used_o     = (op == OP_BEQ) || (op == OP_BNE);
        class_o       = IC_BRANCH;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_o.wreg    = 1'b1;
        ctrl_o.use_imm = 1'b1;
        dst_o          = rt;
        rs_used_o      = (op != OP_LUI);
        case (op)
          OP_ADDI:  ctrl_o.alucontrol = ALU_ADD;
          OP_ADDIU: ctrl_o.alucontrol = ALU_ADDU;
          OP_SLTI:  ctrl_o.alucontrol = ALU_SLT;
          OP_SLTIU: ctrl_o.alucontrol = ALU_SLTU;
          OP_ANDI:  ctrl_o.alucontrol = ALU_AND;
          OP_ORI:   ctrl_o.alucontrol = ALU_OR;
          OP_XORI:  ctrl_o.alucontrol = ALU_XOR;
          default:  ctrl_o.alucontrol = ALU_LUI;
        endcase
      end
      OP_COP0: begin
        // TLB maintenance has no effect on this core and issues as a NOP
        if (instr_i[25]) begin
          if (funct == FN_ERET) begin
            ctrl_o.alucontrol = ALU_ERET;
            class_o           = IC_SINGLE;
          end else if (!(funct inside {FN_TLBR, FN_TLBWI, FN_TLBWR, FN_TLBP})) begin
            invalid_o = 1'b1;
          end
        end else if (rs == RS_MFC0) begin
          ctrl_o.wreg       = 1'b1;
          ctrl_o.alucontrol = ALU_MFC0;
          dst_o             = rt;
          class_o           = IC_SINGLE;
        end else if (rs == RS_MTC0) begin
          ctrl_o.alucontrol = ALU_MTC0;
          rt_used_o         = 1'b1;
          class_o           = IC_SINGLE;
        end else begin
          invalid_o = 1'b1;
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LL: begin
        ctrl_o.wreg    = 1'b1;
        ctrl_o.use_imm = 1'b1;
        ctrl_o.rmem    = 1'b1;
        ctrl_o.memen   = 1'b1;
        dst_o          = rt;
        rs_used_o      = 1'b1;
        class_o        = (op == OP_LL) ? IC_SINGLE : IC_MEM;
      end
      OP_SB, OP_SH, OP_SW, OP_SC: begin
        ctrl_o.use_imm = 1'b1;
        ctrl_o.wmem    = 1'b1;
        ctrl_o.memen   = 1'b1;
        rs_used_o      = 1'b1;
        rt_used_o      = 1'b1;
        class_o        = IC_MEM;
        if (op == OP_SC) begin
          ctrl_o.wreg = 1'b1;
          dst_o       = rt;
          class_o     = IC_SINGLE;
        end
      end
      OP_CACHE: ;
      default: invalid_o = 1'b1;
    endcase
    if (invalid_o) begin
      ctrl_o    = '0;
      class_o   = IC_SINGLE;
      dst_o     = '0;
      rs_used_o = 1'b0;
      rt_used_o = 1'b0;
    end
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Instruction queue between fetch and ID/EX: buffers FETCH_W instr/PC pairs per cycle and
// issues up to ISSUE_W decoded, pairing-checked slots per cycle through a registered stage.
module decode_issue_queue
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush_i,
  input  logic [FETCH_W-1:0]        in_valid_i,
  input  logic [32*FETCH_W-1:0]     in_instr_i,
  input  logic [32*FETCH_W-1:0]     in_pc_i,
  output logic                      in_ready_o,
  input  logic                      out_ready_i,
  output logic [ISSUE_W-1:0]        out_valid_o,
  output logic [32*ISSUE_W-1:0]     out_instr_o,
  output logic [32*ISSUE_W-1:0]     out_pc_o,
  output logic [CTRL_W*ISSUE_W-1:0] out_ctrl_o,
  output logic [ISSUE_W-1:0]        out_invalid_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d, n_push, n_pop;
  logic            push_en, load;

  logic [ISSUE_W-1:0][31:0] h_instr, h_pc;
  ctrl_t        [ISSUE_W-1:0] h_ctrl;
  issue_class_e             h_class [ISSUE_W];
  logic [ISSUE_W-1:0]       h_inv, h_rs_used, h_rt_used, sel_valid;
  logic [ISSUE_W-1:0][4:0]  h_dst, h_rs, h_rt;

  logic [ISSUE_W-1:0]       out_valid_q, out_valid_d, out_inv_q, out_inv_d;
  logic [ISSUE_W-1:0][31:0] out_instr_q, out_instr_d, out_pc_q, out_pc_d;
  ctrl_t        [ISSUE_W-1:0] out_ctrl_q, out_ctrl_d;

  // Free space is judged on the registered count, so a push can never overrun the queue
  assign in_ready_o = (count_q <= CntW'(DEPTH - FETCH_W));
  assign push_en    = in_ready_o && !flush_i;

  always_comb begin
    n_push = '0;
    for (int l = 0; l < FETCH_W; l++) begin
      if (in_valid_i[l]) n_push = n_push + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int l = 0; l < FETCH_W; l++) begin
        if (in_valid_i[l]) begin
          instr_mem[wr_ptr_q + PtrW'(l)] <= in_instr_i[32*l +: 32];
          pc_mem[wr_ptr_q + PtrW'(l)]    <= in_pc_i[32*l +: 32];
        end
      end
    end
  end

  for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot
    assign h_instr[s] = instr_mem[rd_ptr_q + PtrW'(s)];
    assign h_pc[s]    = pc_mem[rd_ptr_q + PtrW'(s)];

    decode_slot u_decode_slot (
      .instr_i   (h_instr[s]),
      .ctrl_o    (h_ctrl[s]),
      .class_o   (h_class[s]),
      .invalid_o (h_inv[s]),
      .dst_o     (h_dst[s]),
      .rs_o      (h_rs[s]),
      .rt_o      (h_rt[s]),
      .rs_used_o (h_rs_used[s]),
      .rt_used_o (h_rt_used[s])
    );
  end

  assign sel_valid[0] = (count_q != '0);

  if (ISSUE_W == 2) begin : g_pair
    logic raw, pair_ok, unused_srcs;
    assign raw = (h_dst[0] != '0) &&
                 ((h_rs_used[1] && (h_rs[1] == h_dst[0])) ||
                  (h_rt_used[1] && (h_rt[1] == h_dst[0])));
    // A branch may lead the pair so its delay slot travels with it, but never trail it
    assign pair_ok = (h_class[0] != IC_SINGLE) && (h_class[1] != IC_SINGLE) &&
                     (h_class[1] != IC_BRANCH) &&
                     !((h_class[0] == IC_MEM) && (h_class[1] == IC_MEM)) && !raw;
    assign sel_valid[1] = (count_q >= CntW'(2)) && pair_ok;
    assign unused_srcs  = ^{h_dst[1], h_rs[0], h_rt[0], h_rs_used[0], h_rt_used[0]};
  end else begin : g_single
    logic unused_srcs;
    assign unused_srcs = ^{h_dst, h_rs, h_rt, h_rs_used, h_rt_used, h_class[0]};
  end

  assign load = !out_valid_q[0] || out_ready_i;

  always_comb begin
    out_valid_d = out_valid_q;
    out_inv_d   = out_inv_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_ctrl_d  = out_ctrl_q;
    n_pop       = '0;
    if (load) begin
      for (int s = 0; s < ISSUE_W; s++) begin
        out_valid_d[s] = sel_valid[s];
        out_inv_d[s]   = sel_valid[s] & h_inv[s];
        out_instr_d[s] = sel_valid[s] ? h_instr[s] : '0;
        out_pc_d[s]    = sel_valid[s] ? h_pc[s] : '0;
        out_ctrl_d[s]  = sel_valid[s] ? h_ctrl[s] : '0;
        if (sel_valid[s]) n_pop = n_pop + CntW'(1);
      end
    end
    count_d  = count_q + (push_en ? n_push : '0) - n_pop;
    wr_ptr_d = wr_ptr_q + (push_en ? PtrW'(n_push) : '0);
    rd_ptr_d = rd_ptr_q + PtrW'(n_pop);
    if (flush_i) begin
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = '0;
      out_inv_d   = '0;
      out_instr_d = '0;
      out_pc_d    = '0;
      out_ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= '0;
      out_inv_q   <= '0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_ctrl_q  <= '0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      out_inv_q   <= out_inv_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_ctrl_q  <= out_ctrl_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_invalid_o = out_inv_q;
  assign out_instr_o   = out_instr_q;
  assign out_pc_o      = out_pc_q;
  assign out_ctrl_o    = out_ctrl_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: pairing, RAW split, branch/delay-slot pairing,
// single-issue classes, back-pressure, flush and asynchronous reset.
module tb_decode_issue_queue;
  import decode_pkg::*;

  localparam logic [31:0] I_ADDU1 = 32'h0043_0821;  // addu $1,$2,$3
  localparam logic [31:0] I_ADDU4 = 32'h00A6_2021;  // addu $4,$5,$6
  localparam logic [31:0] I_ORI7  = 32'h3427_0001;  // ori  $7,$1,1
  localparam logic [31:0] I_BEQ   = 32'h1022_0004;  // beq  $1,$2,+4
  localparam logic [31:0] I_JR    = 32'h03E0_0008;  // jr   $31
  localparam logic [31:0] I_MULT  = 32'h0043_0018;  // mult $2,$3
  localparam logic [31:0] I_DIV   = 32'h0085_001A;  // div  $4,$5
  localparam logic [31:0] I_BAD   = 32'hFC00_0000;  // opcode 6'h3F

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                flush_i = 1'b0;
  logic [1:0]          in_valid_i = '0;
  logic [63:0]         in_instr_i = '0;
  logic [63:0]         in_pc_i = '0;
  logic                in_ready_o;
  logic                out_ready_i = 1'b0;
  logic [1:0]          out_valid_o;
  logic [63:0]         out_instr_o;
  logic [63:0]         out_pc_o;
  logic [2*CTRL_W-1:0] out_ctrl_o;
  logic [1:0]          out_invalid_o;

  int    n_vec = 0;
  int    n_err = 0;
  ctrl_t c_addu, c_ori, c_beq, c_mult;
  logic [31:0] pc;

  always #5 clk = ~clk;

  decode_issue_queue #(
    .DEPTH   (8),
    .FETCH_W (2),
    .ISSUE_W (2)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_instr_i    (in_instr_i),
    .in_pc_i       (in_pc_i),
    .in_ready_o    (in_ready_o),
    .out_ready_i   (out_ready_i),
    .out_valid_o   (out_valid_o),
    .out_instr_o   (out_instr_o),
    .out_pc_o      (out_pc_o),
    .out_ctrl_o    (out_ctrl_o),
    .out_invalid_o (out_invalid_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1);
    in_valid_i = v;
    in_instr_i = {i1, i0};
    in_pc_i    = {p1, p0};
  endtask

  task automatic idle();
    in_valid_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    c_addu = '0; c_addu.wreg = 1'b1; c_addu.regdst = 1'b1; c_addu.alucontrol = ALU_ADDU;
    c_ori  = '0; c_ori.wreg = 1'b1; c_ori.use_imm = 1'b1; c_ori.alucontrol = ALU_OR;
    c_beq  = '0; c_beq.branch = 1'b1;
    c_mult = '0; c_mult.whilo = 2'b11; c_mult.alucontrol = ALU_MULT;

    // Reset held while fetch is already driving
    push(2'b11, I_ADDU1, 32'h10, I_ADDU4, 32'h14);
    #3;
    check("rst_valid", out_valid_o, 2'b00);
    check("rst_invalid", out_invalid_o, 2'b00);
    check("rst_pc", out_pc_o, 64'h0);
    check("rst_instr", out_instr_o, 64'h0);
    check("rst_ctrl", out_ctrl_o, '0);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    tick();
    check("rst_ready", in_ready_o, 1'b1);
    check("rst_valid_after", out_valid_o, 2'b00);

    // Independent pair: two-cycle latency, issued together
    out_ready_i = 1'b1;
    push(2'b11, I_ADDU1, 32'h100, I_ADDU4, 32'h104);
    tick();
    idle();
    check("pair_no_bypass", out_valid_o, 2'b00);
    tick();
    check("pair_valid", out_valid_o, 2'b11);
    check("pair_pc", out_pc_o, {32'h104, 32'h100});
    check("pair_instr1", out_instr_o[63:32], I_ADDU4);
    check("pair_ctrl0", out_ctrl_o[CTRL_W-1:0], c_addu);

    // RAW: ori reads $1 written by addu
    push(2'b11, I_ADDU1, 32'h110, I_ORI7, 32'h114);
    tick();
    idle();
    tick();
    check("raw_first_valid", out_valid_o, 2'b01);
    check("raw_first_pc0", out_pc_o[31:0], 32'h110);
    tick();
    check("raw_second_valid", out_valid_o, 2'b01);
    check("raw_second_pc0", out_pc_o[31:0], 32'h114);
    check("raw_second_ctrl0", out_ctrl_o[CTRL_W-1:0], c_ori);

    // Branch + delay slot pair; JR must not trail in slot 1
    push(2'b11, I_BEQ, 32'h200, I_ADDU4, 32'h204);
    tick();
    idle();
    tick();
    check("beq_valid", out_valid_o, 2'b11);
    check("beq_pc", out_pc_o, {32'h204, 32'h200});
    check("beq_ctrl0", out_ctrl_o[CTRL_W-1:0], c_beq);
    push(2'b11, I_ADDU4, 32'h300, I_JR, 32'h304);
    tick();
    idle();
    tick();
    check("jr_h1_valid", out_valid_o, 2'b01);
    check("jr_h1_pc0", out_pc_o[31:0], 32'h300);
    tick();
    check("jr_alone_valid", out_valid_o, 2'b01);
    check("jr_alone_instr0", out_instr_o[31:0], I_JR);

    // Invalid opcode, MULT, DIV: each issued alone
    push(2'b11, I_BAD, 32'h400, I_MULT, 32'h404);
    tick();
    push(2'b01, I_DIV, 32'h408, 32'h0, 32'h0);
    tick();
    idle();
    check("bad_valid", out_valid_o, 2'b01);
    check("bad_invalid", out_invalid_o, 2'b01);
    check("bad_ctrl0", out_ctrl_o[CTRL_W-1:0], '0);
    check("bad_pc0", out_pc_o[31:0], 32'h400);
    tick();
    check("mult_valid", out_valid_o, 2'b01);
    check("mult_invalid", out_invalid_o, 2'b00);
    check("mult_pc0", out_pc_o[31:0], 32'h404);
    check("mult_ctrl0", out_ctrl_o[CTRL_W-1:0], c_mult);
    tick();
    check("div_valid", out_valid_o, 2'b01);
    check("div_invalid", out_invalid_o, 2'b00);
    check("div_pc0", out_pc_o[31:0], 32'h408);
    tick();
    check("drain_valid", out_valid_o, 2'b00);

    // Fill with the consumer stalled; count goes 2,2,4,6,8 (first pair sits in the output)
    out_ready_i = 1'b0;
    pc = 32'h500;
    for (int k = 0; k < 5; k++) begin
      push(2'b11, I_ADDU4, pc, I_ADDU4, pc + 32'h4);
      tick();
      pc = pc + 32'h8;
      check($sformatf("fill_ready_%0d", k), in_ready_o, (k < 4) ? 1'b1 : 1'b0);
    end
    check("fill_valid", out_valid_o, 2'b11);
    check("fill_pc", out_pc_o, {32'h504, 32'h500});
    push(2'b11, I_ADDU4, 32'h580, I_ADDU4, 32'h584);
    tick();
    tick();
    check("stall_pc", out_pc_o, {32'h504, 32'h500});
    check("stall_ready", in_ready_o, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    idle();
    check("flush_valid", out_valid_o, 2'b00);
    check("flush_ready", in_ready_o, 1'b1);
    out_ready_i = 1'b1;
    tick();
    tick();
    check("flush_drained", out_valid_o, 2'b00);

    // Push coincident with flush into an empty queue is discarded
    flush_i = 1'b1;
    push(2'b11, I_ADDU1, 32'h700, I_ADDU4, 32'h704);
    tick();
    flush_i = 1'b0;
    idle();
    tick();
    tick();
    check("flush_push_dropped", out_valid_o, 2'b00);

    // Asynchronous reset in the middle of traffic
    push(2'b11, I_ADDU1, 32'h800, I_ADDU4, 32'h804);
    tick();
    push(2'b11, I_ADDU1, 32'h808, I_ADDU4, 32'h80C);
    tick();
    check("midrst_pre_valid", out_valid_o, 2'b11);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_valid", out_valid_o, 2'b00);
    check("midrst_pc", out_pc_o, 64'h0);
    check("midrst_ready", in_ready_o, 1'b1);
    idle();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("midrst_ready_after", in_ready_o, 1'b1);
    tick();
    check("midrst_empty", out_valid_o, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
